// File: rtl/fp_addsub_scheduler.sv
// FP32 add/subtract scheduler: round-robin arbitration of NUM_REQ requesters
// onto one shared combinational FP32 adder, with a registered result channel.
// Also contains the shared round-to-nearest-even FP32 adder.

module adder (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);
    logic        sa, sb, sl, ss, eff_sub;
    logic [7:0]  ea, eb, el, es, dexp;
    logic [22:0] fa, fb;
    logic [23:0] ml, ms;
    logic [26:0] ms_ext, ms_al, lost_mask;
    logic [27:0] sum;
    logic [26:0] norm;
    logic [8:0]  exp_n, exp_r;
    logic [4:0]  msb, lshift;
    logic [24:0] rnd;
    logic        rnd_up;
    logic        a_nan, b_nan, a_inf, b_inf;

    // Align, add/subtract magnitudes, normalise and round to nearest even
    always_comb begin
        y         = '0;
        sa        = a[31];
        ea        = a[30:23];
        fa        = a[22:0];
        sb        = b[31];
        eb        = b[30:23];
        fb        = b[22:0];
        a_nan     = (ea == 8'hFF) && (fa != '0);
        b_nan     = (eb == 8'hFF) && (fb != '0);
        a_inf     = (ea == 8'hFF) && (fa == '0);
        b_inf     = (eb == 8'hFF) && (fb == '0);
        lost_mask = '0;
        msb       = '0;
        lshift    = '0;

        // Larger magnitude goes to the "l" side; denormals use exponent 1
        if (a[30:0] >= b[30:0]) begin
            sl = sa; el = (ea == 8'd0) ? 8'd1 : ea; ml = {ea != 8'd0, fa};
            ss = sb; es = (eb == 8'd0) ? 8'd1 : eb; ms = {eb != 8'd0, fb};
        end else begin
            sl = sb; el = (eb == 8'd0) ? 8'd1 : eb; ml = {eb != 8'd0, fb};
            ss = sa; es = (ea == 8'd0) ? 8'd1 : ea; ms = {ea != 8'd0, fa};
        end
        eff_sub = sl ^ ss;
        dexp    = el - es;

        // Three extra bits (guard, round, sticky) below the 24-bit significand
        ms_ext = {ms, 3'b000};
        if (dexp >= 8'd27) begin
            ms_al = {26'd0, |ms};
        end else begin
            lost_mask = (27'd1 << dexp) - 27'd1;
            ms_al     = (ms_ext >> dexp) | {26'd0, |(ms_ext & lost_mask)};
        end

        if (eff_sub) sum = {1'b0, ml, 3'b000} - {1'b0, ms_al};
        else         sum = {1'b0, ml, 3'b000} + {1'b0, ms_al};

        exp_n = {1'b0, el};
        if (sum[27]) begin
            norm  = {sum[27:2], sum[1] | sum[0]};
            exp_n = exp_n + 9'd1;
        end else begin
            for (int unsigned i = 0; i < 27; i++) begin
                if (sum[i]) msb = 5'(i);
            end
            lshift = 5'd26 - msb;
            // Stop shifting at exponent 1 so the result becomes denormal
            if ({4'd0, lshift} >= exp_n) lshift = exp_n[4:0] - 5'd1;
            norm  = sum[26:0] << lshift;
            exp_n = exp_n - {4'd0, lshift};
        end

        rnd_up = norm[2] & (norm[1] | norm[0] | norm[3]);
        rnd    = {1'b0, norm[26:3]} + {24'd0, rnd_up};
        exp_r  = rnd[24] ? exp_n + 9'd1 : exp_n;

        if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
            y = 32'h7FC0_0000;
        end else if (a_inf) begin
            y = {sa, 8'hFF, 23'd0};
        end else if (b_inf) begin
            y = {sb, 8'hFF, 23'd0};
        end else if (sum == '0) begin
            y = {sa & sb, 31'd0};
        end else if (exp_r >= 9'd255) begin
            y = {sl, 8'hFF, 23'd0};
        end else if (rnd[24]) begin
            y = {sl, exp_r[7:0], 23'd0};
        end else begin
            y = {sl, rnd[23] ? exp_r[7:0] : 8'd0, rnd[22:0]};
        end
    end
endmodule

module fp_addsub_scheduler #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ-1:0]      req_op,
    input  logic [32*NUM_REQ-1:0]   req_a,
    input  logic [32*NUM_REQ-1:0]   req_b,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [31:0]             res_data,
    output logic [ID_W-1:0]         res_id,
    output logic                    busy,
    output logic [CNT_W-1:0]        done_cnt
);
    typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

    state_t          state_q;
    logic [31:0]     opa_q, opb_q;
    logic [ID_W-1:0] id_q, rr_ptr_q;
    logic            res_valid_q;
    logic [31:0]     res_data_q;
    logic [ID_W-1:0] res_id_q;
    logic [CNT_W-1:0] done_cnt_q;

    logic            accept_en, accept, gnt_found, cand_valid;
    logic [ID_W-1:0] gnt_idx;
    int unsigned     cand;
    logic [31:0]     sel_a, sel_b, opb_d, sum_y;
    logic            sel_op;

    // Round-robin search starting just after the last granted requester
    always_comb begin
        gnt_found  = 1'b0;
        gnt_idx    = '0;
        cand       = 0;
        cand_valid = 1'b0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            cand       = (32'(rr_ptr_q) + off) % NUM_REQ;
            cand_valid = 1'b0;
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (i == cand) cand_valid = req_valid[i];
            end
            if (!gnt_found && cand_valid) begin
                gnt_found = 1'b1;
                gnt_idx   = ID_W'(cand);
            end
        end
    end

    assign accept_en = rst_n && ((state_q == IDLE) || ((state_q == HOLD) && res_ready));
    assign accept    = accept_en && gnt_found;

    // One-hot ready and operand selection for the granted requester
    always_comb begin
        req_ready = '0;
        sel_a     = '0;
        sel_b     = '0;
        sel_op    = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (ID_W'(i) == gnt_idx) begin
                req_ready[i] = accept;
                sel_a        = req_a[32*i +: 32];
                sel_b        = req_b[32*i +: 32];
                sel_op       = req_op[i];
            end
        end
    end

    // Subtraction is addition with b's sign inverted
    assign opb_d = {sel_b[31] ^ sel_op, sel_b[30:0]};

    adder u_adder (
        .a (opa_q),
        .b (opb_q),
        .y (sum_y)
    );

    // Issue/result FSM: IDLE -> EXEC (one cycle) -> HOLD until consumed
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            opa_q       <= '0;
            opb_q       <= '0;
            id_q        <= '0;
            rr_ptr_q    <= ID_W'(NUM_REQ - 1);
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_id_q    <= '0;
            done_cnt_q  <= '0;
        end else begin
            if (res_valid_q && res_ready) done_cnt_q <= done_cnt_q + CNT_W'(1);
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        opa_q    <= sel_a;
                        opb_q    <= opb_d;
                        id_q     <= gnt_idx;
                        rr_ptr_q <= gnt_idx;
                        state_q  <= EXEC;
                    end
                end
                EXEC: begin
                    res_data_q  <= sum_y;
                    res_id_q    <= id_q;
                    res_valid_q <= 1'b1;
                    state_q     <= HOLD;
                end
                HOLD: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        if (accept) begin
                            opa_q    <= sel_a;
                            opb_q    <= opb_d;
                            id_q     <= gnt_idx;
                            rr_ptr_q <= gnt_idx;
                            state_q  <= EXEC;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_id    = res_id_q;
    assign busy      = (state_q != IDLE);
    assign done_cnt  = done_cnt_q;
endmodule
